// File: rtl/pcs_pack_pkg.sv
// Shared PCS packet definitions: type codes, header field positions and the receive FSM states.
// Used by both the RX unpacker and the TX packer.
package pcs_pack_pkg;

    localparam logic [7:0] PKT_VIDEO  = 8'h01;
    localparam logic [7:0] PKT_AUDIO0 = 8'h02;
    localparam logic [7:0] PKT_AUDIO1 = 8'h03;
    localparam logic [7:0] PKT_UART   = 8'h04;
    localparam logic [7:0] PKT_TIMING = 8'h05;
    localparam logic [7:0] PKT_VSYNC  = 8'h06;

    localparam int HDR_TYPE_MSB = 63;
    localparam int HDR_TYPE_LSB = 56;
    localparam int HDR_LEN_MSB  = 55;
    localparam int HDR_LEN_LSB  = 48;

    // Timing header payload fields inside the type-specific area
    localparam int TIM_RES_MSB   = 47;
    localparam int TIM_RES_LSB   = 40;
    localparam int TIM_LOCK_BIT  = 39;
    localparam int TIM_WIDTH_MSB = 38;
    localparam int TIM_WIDTH_LSB = 26;
    localparam int TIM_HEIGH_MSB = 25;
    localparam int TIM_HEIGH_LSB = 13;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VIDEO,
        ST_AUDIO0,
        ST_AUDIO1,
        ST_UART,
        ST_DROP
    } rx_state_e;

    function automatic logic [63:0] make_header(input logic [7:0] pkt_type,
                                                input logic [7:0] pkt_len,
                                                input logic [47:0] info);
        return {pkt_type, pkt_len, info};
    endfunction

endpackage

// File: rtl/pcs_rx_hdr_decode.sv
// Combinational header field extraction and legality check.
// A UART header is always reported legal; whether it is serviced is decided by the unpacker.
module pcs_rx_hdr_decode
    import pcs_pack_pkg::*;
#(
    parameter int p_video_max_len = 240
) (
    input  logic [63:0] i_hdr,
    output logic [7:0]  o_type,
    output logic [7:0]  o_len,
    output logic        o_legal
);

    always_comb begin
        o_type  = i_hdr[HDR_TYPE_MSB:HDR_TYPE_LSB];
        o_len   = i_hdr[HDR_LEN_MSB:HDR_LEN_LSB];
        o_legal = 1'b0;
        case (o_type)
            PKT_VIDEO:  o_legal = (int'(o_len) <= p_video_max_len);
            PKT_AUDIO0: o_legal = 1'b1;
            PKT_AUDIO1: o_legal = 1'b1;
            PKT_UART:   o_legal = 1'b1;
            // Control headers carry no payload words
            PKT_TIMING: o_legal = (o_len == 8'd0);
            PKT_VSYNC:  o_legal = (o_len == 8'd0);
            default:    o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/pcs_rx_unpack.sv
// PCS receive unpacker: routes payload words to video/audio/UART writers and decodes control headers.
// Define PCS_RX_UART_EN to service UART packets; otherwise they are silently dropped.
module pcs_rx_unpack
    import pcs_pack_pkg::*;
#(
    parameter int p_debug_en      = 0,
    parameter int p_video_max_len = 240
) (
    input  logic        i_pcs_clk,
    input  logic        i_rst_n,
    input  logic        i_pcs_valid,
    input  logic        i_pcs_head,
    input  logic [63:0] i_pcs_data,
    output logic        o_video_wr_en,
    output logic [63:0] o_video_data,
    input  logic        i_video_full,
    output logic        o_audio0_wr_en,
    output logic [63:0] o_audio0_data,
    output logic        o_audio1_wr_en,
    output logic [63:0] o_audio1_data,
    output logic        o_uart_wr_en,
    output logic [31:0] o_uart_data,
    output logic        o_vsyn_pulse,
    output logic [7:0]  o_resolution,
    output logic        o_video_lock,
    output logic [12:0] o_width,
    output logic [12:0] o_heigh,
    output logic [15:0] o_err_cnt,
    output logic        o_video_ovf,
    output logic [2:0]  o_dbg_state,
    output logic [7:0]  o_dbg_cnt
);

    rx_state_e   state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  hdr_type;
    logic [7:0]  hdr_len;
    logic        hdr_legal;

    logic        err_hit;
    logic        vid_wr_d, a0_wr_d, a1_wr_d, uart_wr_d;
    logic        vsyn_d, tim_ld_d, ovf_set;

    logic        vid_wr_q, a0_wr_q, a1_wr_q, vsyn_q, lock_q, ovf_q;
    logic [63:0] vid_data_q, a0_data_q, a1_data_q;
    logic [7:0]  res_q;
    logic [12:0] width_q, heigh_q;
    logic [15:0] err_cnt_q;

    pcs_rx_hdr_decode #(
        .p_video_max_len(p_video_max_len)
    ) u_hdr_decode (
        .i_hdr  (i_pcs_data),
        .o_type (hdr_type),
        .o_len  (hdr_len),
        .o_legal(hdr_legal)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_hit   = 1'b0;
        vid_wr_d  = 1'b0;
        a0_wr_d   = 1'b0;
        a1_wr_d   = 1'b0;
        uart_wr_d = 1'b0;
        vsyn_d    = 1'b0;
        tim_ld_d  = 1'b0;
        ovf_set   = 1'b0;
        if (i_pcs_valid) begin
            if (i_pcs_head) begin
                // A truncated packet and an illegal header in one cycle still count once
                err_hit = (cnt_q != 8'd0) || !hdr_legal;
                cnt_d   = hdr_len;
                state_d = ST_IDLE;
                if (hdr_len != 8'd0) begin
                    state_d = ST_DROP;
                    if (hdr_legal) begin
                        case (hdr_type)
                            PKT_VIDEO:  state_d = ST_VIDEO;
                            PKT_AUDIO0: state_d = ST_AUDIO0;
                            PKT_AUDIO1: state_d = ST_AUDIO1;
`ifdef PCS_RX_UART_EN
                            PKT_UART:   state_d = ST_UART;
`endif
                            default:    state_d = ST_DROP;
                        endcase
                    end
                end else if (hdr_legal) begin
                    tim_ld_d = (hdr_type == PKT_TIMING);
                    vsyn_d   = (hdr_type == PKT_VSYNC);
                end
            end else if (cnt_q == 8'd0) begin
                err_hit = 1'b1;
            end else begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = ST_IDLE;
                end
                case (state_q)
                    ST_VIDEO: begin
                        ovf_set  = i_video_full;
                        vid_wr_d = !i_video_full;
                    end
                    ST_AUDIO0: a0_wr_d   = 1'b1;
                    ST_AUDIO1: a1_wr_d   = 1'b1;
                    ST_UART:   uart_wr_d = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge i_pcs_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            vid_wr_q   <= 1'b0;
            a0_wr_q    <= 1'b0;
            a1_wr_q    <= 1'b0;
            vsyn_q     <= 1'b0;
            vid_data_q <= 64'd0;
            a0_data_q  <= 64'd0;
            a1_data_q  <= 64'd0;
            res_q      <= 8'd0;
            lock_q     <= 1'b0;
            width_q    <= 13'd0;
            heigh_q    <= 13'd0;
            ovf_q      <= 1'b0;
            err_cnt_q  <= 16'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            vid_wr_q <= vid_wr_d;
            a0_wr_q  <= a0_wr_d;
            a1_wr_q  <= a1_wr_d;
            vsyn_q   <= vsyn_d;
            if (vid_wr_d) vid_data_q <= i_pcs_data;
            if (a0_wr_d)  a0_data_q  <= i_pcs_data;
            if (a1_wr_d)  a1_data_q  <= i_pcs_data;
            if (tim_ld_d) begin
                res_q   <= i_pcs_data[TIM_RES_MSB:TIM_RES_LSB];
                lock_q  <= i_pcs_data[TIM_LOCK_BIT];
                width_q <= i_pcs_data[TIM_WIDTH_MSB:TIM_WIDTH_LSB];
                heigh_q <= i_pcs_data[TIM_HEIGH_MSB:TIM_HEIGH_LSB];
            end
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (vsyn_d) begin
                ovf_q <= 1'b0;
            end
            if (err_hit && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

`ifdef PCS_RX_UART_EN
    logic        uart_wr_q;
    logic [31:0] uart_data_q;

    always_ff @(posedge i_pcs_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            uart_wr_q   <= 1'b0;
            uart_data_q <= 32'd0;
        end else begin
            uart_wr_q <= uart_wr_d;
            if (uart_wr_d) uart_data_q <= i_pcs_data[31:0];
        end
    end

    assign o_uart_wr_en = uart_wr_q;
    assign o_uart_data  = uart_data_q;
`else
    assign o_uart_wr_en = 1'b0;
    assign o_uart_data  = 32'd0;
`endif

    assign o_video_wr_en  = vid_wr_q;
    assign o_video_data   = vid_data_q;
    assign o_audio0_wr_en = a0_wr_q;
    assign o_audio0_data  = a0_data_q;
    assign o_audio1_wr_en = a1_wr_q;
    assign o_audio1_data  = a1_data_q;
    assign o_vsyn_pulse   = vsyn_q;
    assign o_resolution   = res_q;
    assign o_video_lock   = lock_q;
    assign o_width        = width_q;
    assign o_heigh        = heigh_q;
    assign o_err_cnt      = err_cnt_q;
    assign o_video_ovf    = ovf_q;

    generate
        if (p_debug_en != 0) begin : g_dbg
            assign o_dbg_state = state_q;
            assign o_dbg_cnt   = cnt_q;
        end else begin : g_no_dbg
            assign o_dbg_state = 3'd0;
            assign o_dbg_cnt   = 8'd0;
        end
    endgenerate

endmodule
